// File: rtl/conv_ctrl_fsm.sv
// 3x3 / pad-1 / stride-1 convolution sequencer over a runtime-sized plane: drives MAC tap
// enables, weight select, input-map reads and a PIPE_LAT-deep output stream to the accumulator.
module conv_ctrl_fsm #(
  parameter int DIM_W    = 6,
  parameter int ICG_W    = 1,
  parameter int OCH_W    = 8,
  parameter int PIPE_LAT = 6,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              conv_start,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [ICG_W-1:0]  cfg_icg,
  input  logic [OCH_W-1:0]  cfg_och,
  input  logic              conv_abort,
  input  logic              acc_rdy,
  output logic              acc_vld,
  output logic [ADDR_W-1:0] acc_info,
  output logic              busy,
  output logic              conv_done,
  output logic              cfg_err,
  output logic              pipe_en,
  output logic [9:0]        pe_en,
  output logic [ICG_W:0]    weight_sel,
  output logic              imap_ren,
  output logic [ADDR_W-1:0] imap_raddr,
  output logic [OCH_W-1:0]  out_ch_cnt,
  output logic [ICG_W-1:0]  in_ch_cnt,
  output logic [4:0]        identity_sel
);

  localparam int CW = 2 * DIM_W;
  localparam int PW = 2 * DIM_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, CONV, DRAIN} state_t;

  state_t            state;
  logic [DIM_W-1:0]  lat_h;
  logic [DIM_W-1:0]  lat_w;
  logic [ICG_W-1:0]  lat_icg;
  logic [OCH_W-1:0]  lat_och;
  logic [DIM_W:0]    setup_cnt;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  col;
  logic [CW-1:0]     imap_cnt;
  logic [CW-1:0]     omap_cnt;
  logic [ICG_W-1:0]  omap_icg;
  logic [OCH_W-1:0]  omap_och;
  logic [PIPE_LAT-1:0] dly;

  logic [PW-1:0] plane_max;
  logic          col_last, row_last, icg_last, och_last, plane_end;
  logic          setup_end, imap_wrap;
  logic          hs, om_cnt_last, om_icg_last, om_och_last, last_hs;
  logic [2:0]    row_ok, col_ok;

  always_comb begin
    // Full-width product so the wrap point is exact for the largest plane.
    plane_max   = (PW'(lat_h) + PW'(1)) * (PW'(lat_w) + PW'(1)) - PW'(1);
    col_last    = (col == lat_w);
    row_last    = (row == lat_h);
    icg_last    = (in_ch_cnt == lat_icg);
    och_last    = (out_ch_cnt == lat_och);
    plane_end   = col_last && row_last;
    setup_end   = (setup_cnt == ({1'b0, lat_w} + (DIM_W+1)'(2)));
    imap_wrap   = (PW'(imap_cnt) == plane_max);
    hs          = acc_vld && acc_rdy;
    om_cnt_last = (PW'(omap_cnt) == plane_max);
    om_icg_last = (omap_icg == lat_icg);
    om_och_last = (omap_och == lat_och);
    last_hs     = hs && om_cnt_last && om_icg_last && om_och_last;
  end

  assign busy         = (state != IDLE);
  assign pipe_en      = busy && acc_rdy;
  assign imap_ren     = pipe_en && ((state == SETUP) || (state == CONV));
  assign acc_vld      = dly[PIPE_LAT-1];
  assign acc_info     = ADDR_W'({omap_och, omap_icg, omap_cnt});
  assign imap_raddr   = ADDR_W'({in_ch_cnt, imap_cnt});
  assign weight_sel   = {out_ch_cnt[0], in_ch_cnt};
  assign identity_sel = out_ch_cnt[4:0];

  // Tap row i looks at pixel row+1-i: i=0 falls off the bottom edge, i=2 off the top.
  always_comb begin
    row_ok = {row != '0, 1'b1, row != lat_h};
    col_ok = {col != '0, 1'b1, col != lat_w};
    pe_en  = '0;
    if (state == CONV) begin
      pe_en[9] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          pe_en[3*i+j] = row_ok[i] && col_ok[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (conv_abort && state != IDLE)) begin
      state      <= IDLE;
      lat_h      <= '0;
      lat_w      <= '0;
      lat_icg    <= '0;
      lat_och    <= '0;
      setup_cnt  <= '0;
      row        <= '0;
      col        <= '0;
      in_ch_cnt  <= '0;
      out_ch_cnt <= '0;
      imap_cnt   <= '0;
      omap_cnt   <= '0;
      omap_icg   <= '0;
      omap_och   <= '0;
      dly        <= '0;
      conv_done  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      cfg_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (conv_start) begin
            if (cfg_h == '0 || cfg_w == '0) begin
              cfg_err <= 1'b1;
            end else begin
              lat_h   <= cfg_h;
              lat_w   <= cfg_w;
              lat_icg <= cfg_icg;
              lat_och <= cfg_och;
              state   <= SETUP;
            end
          end
        end
        SETUP: begin
          if (pipe_en) begin
            if (setup_end) begin
              setup_cnt <= '0;
              state     <= CONV;
            end else begin
              setup_cnt <= setup_cnt + 1'b1;
            end
          end
        end
        CONV: begin
          if (pipe_en) begin
            col <= col_last ? '0 : col + 1'b1;
            if (col_last) row <= row_last ? '0 : row + 1'b1;
            if (plane_end) begin
              in_ch_cnt <= icg_last ? '0 : in_ch_cnt + 1'b1;
              if (icg_last) begin
                out_ch_cnt <= och_last ? '0 : out_ch_cnt + 1'b1;
                if (och_last) state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (last_hs) begin
            state     <= IDLE;
            conv_done <= 1'b1;
            imap_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (imap_ren) imap_cnt <= imap_wrap ? '0 : imap_cnt + 1'b1;

      // Delay line tracks the MAC pipeline, so it moves only when the array does.
      if (pipe_en) begin
        dly[0] <= (state == CONV);
        for (int k = 1; k < PIPE_LAT; k++) dly[k] <= dly[k-1];
      end

      if (hs) begin
        if (om_cnt_last) begin
          omap_cnt <= '0;
          if (om_icg_last) begin
            omap_icg <= '0;
            omap_och <= om_och_last ? '0 : omap_och + 1'b1;
          end else begin
            omap_icg <= omap_icg + 1'b1;
          end
        end else begin
          omap_cnt <= omap_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_ctrl_fsm.sv
// Randomised bench for conv_ctrl_fsm, checked against an arithmetic model of the scan order.
module tb_conv_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n, conv_start, conv_abort, acc_rdy;
  logic [5:0]  cfg_h, cfg_w;
  logic [0:0]  cfg_icg;
  logic [7:0]  cfg_och;
  logic        acc_vld, busy, conv_done, cfg_err, pipe_en, imap_ren;
  logic [31:0] acc_info, imap_raddr;
  logic [9:0]  pe_en;
  logic [1:0]  weight_sel;
  logic [7:0]  out_ch_cnt;
  logic [0:0]  in_ch_cnt;
  logic [4:0]  identity_sel;

  conv_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .conv_start(conv_start), .cfg_h(cfg_h), .cfg_w(cfg_w),
    .cfg_icg(cfg_icg), .cfg_och(cfg_och), .conv_abort(conv_abort), .acc_rdy(acc_rdy),
    .acc_vld(acc_vld), .acc_info(acc_info), .busy(busy), .conv_done(conv_done),
    .cfg_err(cfg_err), .pipe_en(pipe_en), .pe_en(pe_en), .weight_sel(weight_sel),
    .imap_ren(imap_ren), .imap_raddr(imap_raddr), .out_ch_cnt(out_ch_cnt),
    .in_ch_cnt(in_ch_cnt), .identity_sel(identity_sel)
  );

  always #5 clk = ~clk;

  logic [95:0] all_out;
  logic [86:0] snap;
  assign all_out = {acc_vld, acc_info, busy, conv_done, cfg_err, pipe_en, pe_en, weight_sel,
                    imap_ren, imap_raddr, out_ch_cnt, in_ch_cnt, identity_sel};
  assign snap    = {acc_vld, acc_info, busy, pe_en, weight_sel, imap_raddr, out_ch_cnt, in_ch_cnt};

  int n_cmp = 0;
  int n_err = 0;

  logic [25:0] cq[$];
  logic [31:0] rq[$];
  logic [31:0] aq[$];
  logic [31:0] basic_aq[$];
  int setup_steps, conv_steps, first_vld, done_cnt, done_busy, stall_bad;

  function automatic logic [9:0] exp_mask(int h, int w, int r, int c);
    logic [9:0] m;
    m = 10'b10_0000_0000;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int pr, pc;
        pr = r + 1 - i;
        pc = c + 1 - j;
        if (pr >= 0 && pr <= h && pc >= 0 && pc <= w) m[3*i+j] = 1'b1;
      end
    end
    return m;
  endfunction

  // Drives one run and records what the DUT produced; kill_mode 1 aborts at CONV step
  // kill_step, kill_mode 2 pulses reset in the first DRAIN cycle.
  task automatic run_conv(input int h, input int w, input int icg, input int och,
                          input int stall_pct, input int kill_mode, input int kill_step);
    bit started, fin, prev_busy, prev_rdy;
    int pcount;
    logic [86:0] prev_snap;
    cq.delete(); rq.delete(); aq.delete();
    setup_steps = 0; conv_steps = 0; first_vld = -1;
    done_cnt = 0; done_busy = 0; stall_bad = 0;
    started = 0; fin = 0; pcount = 0;
    cfg_h = 6'(h); cfg_w = 6'(w); cfg_icg = 1'(icg); cfg_och = 8'(och);
    @(posedge clk); #1;
    conv_start = 1'b1;
    acc_rdy    = 1'b1;
    #1;
    prev_snap = snap; prev_busy = busy; prev_rdy = acc_rdy;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(posedge clk); #1;
      conv_start = pe_en[9] ? 1'($urandom_range(1)) : 1'b0;
      acc_rdy    = ($urandom_range(99) >= stall_pct);
      if (kill_mode == 1 && pe_en[9] && conv_steps == kill_step) begin
        conv_abort = 1'b1; conv_start = 1'b0;
        @(posedge clk); #1;
        conv_abort = 1'b0;
        #1;
        return;
      end
      if (kill_mode == 2 && started && busy && !pe_en[9]) begin
        rst_n = 1'b0; conv_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        return;
      end
      #1;
      if (prev_busy && !prev_rdy && snap !== prev_snap) stall_bad++;
      if (pe_en[9]) started = 1;
      if (acc_vld && first_vld < 0) first_vld = pcount;
      if (pipe_en && started) pcount++;
      if (pipe_en && pe_en[9]) begin
        cq.push_back({pe_en, weight_sel, identity_sel, out_ch_cnt, in_ch_cnt});
        conv_steps++;
      end else if (pipe_en && !started) begin
        setup_steps++;
      end
      if (imap_ren) rq.push_back(imap_raddr);
      if (acc_vld && acc_rdy) aq.push_back(acc_info);
      if (conv_done) begin
        done_cnt++;
        if (busy) done_busy++;
        fin = 1;
      end
      prev_snap = snap; prev_busy = busy; prev_rdy = acc_rdy;
    end
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL run_timeout: no conv_done within budget, required one");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; conv_start = 1'b0; conv_abort = 1'b0; acc_rdy = 1'b1;
    cfg_h = '0; cfg_w = '0; cfg_icg = '0; cfg_och = '0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (all_out !== 96'd0) begin n_err++; $display("FAIL reset_outputs got %h want 0", all_out); end
    rst_n = 1'b1;
    @(posedge clk); #2;
    n_cmp++;
    if (all_out !== 96'd0) begin n_err++; $display("FAIL reset_idle got %h want 0", all_out); end
  endtask

  task automatic test_basic();
    int          kk[5];
    logic [9:0]  mm[5];
    kk = '{0, 1, 3, 15, 5};
    mm = '{10'b1000011011, 10'b1000111111, 10'b1000110110, 10'b1110110000, 10'b1111111111};
    run_conv(3, 3, 1, 1, 0, 0, 0);
    n_cmp++; if (setup_steps !== 6) begin n_err++; $display("FAIL basic_setup got %0d want 6", setup_steps); end
    n_cmp++; if (conv_steps !== 64) begin n_err++; $display("FAIL basic_conv got %0d want 64", conv_steps); end
    n_cmp++; if (rq.size() !== 70) begin n_err++; $display("FAIL basic_ren got %0d want 70", rq.size()); end
    n_cmp++; if (aq.size() !== 64) begin n_err++; $display("FAIL basic_vld got %0d want 64", aq.size()); end
    n_cmp++; if (first_vld !== 6) begin n_err++; $display("FAIL basic_first_vld got %0d want 6", first_vld); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    n_cmp++; if (done_busy !== 0) begin n_err++; $display("FAIL basic_busy_at_done got %0d want 0", done_busy); end
    n_cmp++;
    if (aq.size() == 0 || aq[aq.size()-1] !== 32'h0000_300F) begin
      n_err++; $display("FAIL basic_last_info got %h want 0000300f", aq.size() ? aq[aq.size()-1] : 32'hx);
    end
    for (int t = 0; t < 5; t++) begin
      n_cmp++;
      if (cq.size() <= kk[t] || cq[kk[t]][25:16] !== mm[t]) begin
        n_err++;
        $display("FAIL basic_mask step %0d got %b want %b", kk[t],
                 cq.size() > kk[t] ? cq[kk[t]][25:16] : 10'bx, mm[t]);
      end
    end
    basic_aq = aq;
    @(posedge clk); #2;
    n_cmp++;
    if ({conv_done, busy} !== 2'b00) begin n_err++; $display("FAIL basic_after_done got %b want 00", {conv_done, busy}); end
  endtask

  task automatic test_backpressure();
    run_conv(3, 3, 1, 1, 50, 0, 0);
    n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL bp_frozen got %0d moves want 0", stall_bad); end
    n_cmp++; if (conv_steps !== 64) begin n_err++; $display("FAIL bp_conv got %0d want 64", conv_steps); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    n_cmp++;
    if (aq.size() !== basic_aq.size()) begin n_err++; $display("FAIL bp_count got %0d want %0d", aq.size(), basic_aq.size()); end
    for (int j = 0; j < aq.size() && j < basic_aq.size(); j++) begin
      n_cmp++;
      if (aq[j] !== basic_aq[j]) begin n_err++; $display("FAIL bp_info #%0d got %h want %h", j, aq[j], basic_aq[j]); end
    end
  endtask

  task automatic test_random_cfg();
    for (int it = 0; it < 6; it++) begin
      int h, w, icg, och, plane, total;
      if (it == 0) begin h = 3; w = 3; icg = 1; och = 1; end
      else if (it == 1) begin h = 1; w = 1; icg = 0; och = 33; end
      else begin
        h = $urandom_range(5, 1); w = $urandom_range(5, 1);
        icg = $urandom_range(1); och = $urandom_range(4);
      end
      run_conv(h, w, icg, och, (it * 10) % 60, 0, 0);
      plane = (h + 1) * (w + 1);
      total = plane * (icg + 1) * (och + 1);
      n_cmp++; if (setup_steps !== w + 3) begin n_err++; $display("FAIL rnd%0d_setup got %0d want %0d", it, setup_steps, w + 3); end
      n_cmp++; if (conv_steps !== total) begin n_err++; $display("FAIL rnd%0d_conv got %0d want %0d", it, conv_steps, total); end
      n_cmp++; if (aq.size() !== total) begin n_err++; $display("FAIL rnd%0d_hs got %0d want %0d", it, aq.size(), total); end
      n_cmp++; if (rq.size() !== total + w + 3) begin n_err++; $display("FAIL rnd%0d_ren got %0d want %0d", it, rq.size(), total + w + 3); end
      n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL rnd%0d_frozen got %0d want 0", it, stall_bad); end
      n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rnd%0d_done got %0d want 1", it, done_cnt); end
      for (int k = 0; k < cq.size(); k++) begin
        int pix, ic;
        logic [7:0]  oc8;
        logic [25:0] ec;
        pix = k % plane;
        ic  = (k / plane) % (icg + 1);
        oc8 = 8'(k / (plane * (icg + 1)));
        ec  = {exp_mask(h, w, pix / (w + 1), pix % (w + 1)), oc8[0], 1'(ic), oc8[4:0], oc8, 1'(ic)};
        n_cmp++;
        if (cq[k] !== ec) begin n_err++; $display("FAIL rnd%0d_step #%0d got %h want %h", it, k, cq[k], ec); end
      end
      for (int n = 0; n < rq.size(); n++) begin
        int ic;
        logic [31:0] er;
        ic = (n < w + 3) ? 0 : ((n - (w + 3)) / plane) % (icg + 1);
        er = (32'(ic) << 12) | 32'(n % plane);
        n_cmp++;
        if (rq[n] !== er) begin n_err++; $display("FAIL rnd%0d_raddr #%0d got %h want %h", it, n, rq[n], er); end
      end
      for (int j = 0; j < aq.size(); j++) begin
        logic [31:0] ea;
        ea = (32'(j / (plane * (icg + 1))) << 13) | (32'((j / plane) % (icg + 1)) << 12) | 32'(j % plane);
        n_cmp++;
        if (aq[j] !== ea) begin n_err++; $display("FAIL rnd%0d_info #%0d got %h want %h", it, j, aq[j], ea); end
      end
    end
  endtask

  task automatic test_abort();
    int bad;
    run_conv(3, 3, 1, 1, 0, 1, 8);
    n_cmp++; if (conv_steps !== 8) begin n_err++; $display("FAIL abort_reached got %0d steps want 8", conv_steps); end
    n_cmp++; if (all_out !== 96'd0) begin n_err++; $display("FAIL abort_outputs got %h want 0", all_out); end
    bad = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (conv_done || busy) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
    run_conv(3, 3, 1, 1, 0, 0, 0);
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL abort_rerun_done got %0d want 1", done_cnt); end
    n_cmp++;
    if (aq.size() !== basic_aq.size()) begin n_err++; $display("FAIL abort_rerun_count got %0d want %0d", aq.size(), basic_aq.size()); end
    for (int j = 0; j < aq.size() && j < basic_aq.size(); j++) begin
      n_cmp++;
      if (aq[j] !== basic_aq[j]) begin n_err++; $display("FAIL abort_rerun_info #%0d got %h want %h", j, aq[j], basic_aq[j]); end
    end
  endtask

  task automatic test_cfg_err();
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      cfg_h = (t == 0) ? 6'd3 : 6'd0;
      cfg_w = (t == 0) ? 6'd0 : 6'd3;
      conv_start = 1'b1;
      @(posedge clk); #1;
      conv_start = 1'b0;
      #1;
      n_cmp++;
      if ({cfg_err, busy} !== 2'b10) begin n_err++; $display("FAIL cfg_err%0d_pulse got %b want 10", t, {cfg_err, busy}); end
      @(posedge clk); #2;
      n_cmp++;
      if ({cfg_err, busy} !== 2'b00) begin n_err++; $display("FAIL cfg_err%0d_clear got %b want 00", t, {cfg_err, busy}); end
    end
  endtask

  task automatic test_robust();
    int bad;
    run_conv(2, 4, 1, 2, 20, 2, 0);
    n_cmp++; if (all_out !== 96'd0) begin n_err++; $display("FAIL drain_reset_outputs got %h want 0", all_out); end
    bad = 0;
    repeat (3) begin
      @(posedge clk); #2;
      if (conv_done || busy) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL drain_reset_idle got %0d active cycles want 0", bad); end
    run_conv(3, 3, 1, 1, 30, 0, 0);
    n_cmp++; if (aq.size() !== 64) begin n_err++; $display("FAIL robust_rerun got %0d want 64", aq.size()); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL robust_done got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_cfg();
    test_abort();
    test_cfg_err();
    test_robust();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
